bgr_palette_rom: RTL and testbench
==================================

BGR_PALETTE_ROM -- requirements
Module: bgr_palette_rom

Interface
REQ-001 Parameter PIX_DEPTH, default 307200: pixel-index ROM depth (640x480 frame).
REQ-002 Parameter PIX_INIT, default "bgr_pixel.mif": pixel-index ROM init file.
REQ-003 Parameter PAL_INIT, default "bgr_color.mif": 256-entry palette ROM init file.
REQ-004 Parameter SPR_DEPTH, default 784: sprite ROM depth (28x28 tile, blue_NE image).
REQ-005 Parameter SPR_INIT, default "blue_NE.mif": sprite ROM init file.
REQ-006 iVGA_CLK  in  1  sole clock; all storage samples on its rising edge.
REQ-007 iRST_n  in  1  reset, asynchronous assert, active-low.
REQ-008 address_a  in  19  pixel-index read address, port A.
REQ-009 rden_a  in  1  port A read enable.
REQ-010 address_b  in  19  pixel-index read address, port B.
REQ-011 rden_b  in  1  port B read enable.
REQ-012 q_a  out  8  palette index read on port A.
REQ-013 q_b  out  8  palette index read on port B.
REQ-014 bgr_data  out  24  palette colour for q_a, {B[23:16],G[15:8],R[7:0]}.
REQ-015 spr_addr  in  10  sprite read address (row*28+col).
REQ-016 spr_q  out  8  sprite palette index.

Function
REQ-017 Pixel ROM SHALL be read-only, 8 bits wide, PIX_DEPTH deep, two independent read ports sharing one storage array, contents loaded from PIX_INIT at elaboration.
REQ-018 Port A: on a rising edge with rden_a=1, q_a SHALL update to ROM[address_a]; latency exactly 1 cycle.
REQ-019 Port A: with rden_a=0, q_a SHALL hold its previous value.
REQ-020 Port B SHALL behave identically to port A using address_b/rden_b/q_b, independently of port A; equal addresses on both ports in the same cycle SHALL return identical data.
REQ-021 Address >= PIX_DEPTH SHALL return 8'h00 (no wrap-around, no X).
REQ-022 Palette ROM SHALL be 256x24, loaded from PAL_INIT, addressed by the registered q_a.
REQ-023 bgr_data SHALL update every rising edge to PAL[q_a]; total latency from address_a to bgr_data is exactly 2 cycles, fully pipelined (one new address per cycle).
REQ-024 Palette stage SHALL NOT be gated by rden_a; it re-reads the held q_a.
REQ-025 Sprite ROM SHALL be SPR_DEPTH x 8, loaded from SPR_INIT; spr_q SHALL update every rising edge to SPR[spr_addr], latency 1 cycle; spr_addr >= SPR_DEPTH SHALL return 8'h00.
REQ-026 All address inputs SHALL be registered internally; outputs SHALL be driven directly from registers, no combinational path input->output.

Reset
REQ-027 iRST_n=0 SHALL asynchronously clear q_a, q_b, spr_q to 8'h00 and bgr_data to 24'h000000.
REQ-028 ROM contents SHALL be unaffected by reset.
REQ-029 Reset assertion mid-pipeline SHALL discard in-flight reads; after release, first valid q_a follows the first enabled edge, first valid bgr_data one edge later.
REQ-030 Reset release SHALL be sampled on iVGA_CLK; no output changes on the release edge other than normal loading.

Structure
REQ-031 A shared package SHALL hold FRAME_W=640, FRAME_H=480, SPR_W=28, palette depth 256, and the wall colour constant 24'hFF5757.
REQ-032 One sub-module, rom_sync (generic parameterised width/depth/init, registered read, enable, out-of-range zero), SHALL be instantiated for pixel (dual-port variant), palette and sprite storage.

Verification
REQ-033 Test init: PIX[a]=a[7:0], PAL[i]={i,~i,i}, SPR[s]=s[7:0]; address_a=5, rden_a=1 -> q_a=8'h05 after 1 edge, bgr_data=24'h05FA05 after 2 edges.
REQ-034 Stream address_a=0,1,2,... each cycle -> q_a=0,1,2,... and bgr_data follows with 1-cycle offset, no bubbles.
REQ-035 address_a=300, rden_a=1 then rden_a=0 with address_a=7 -> q_a stays 8'h2C (300 mod 256); bgr_data stays 24'h2CD32C.
REQ-036 address_a=10, address_b=307199 simultaneously -> q_a=8'h0A, q_b=8'hFF; address_b=307200 -> q_b=8'h00.
REQ-037 spr_addr=783 -> spr_q=8'h0F after 1 edge; spr_addr=900 -> spr_q=8'h00.
REQ-038 Assert iRST_n=0 between edges mid-stream -> all outputs 0 immediately; release, address_a=3 -> q_a=8'h03 one edge later, bgr_data=24'h03FC03 two edges later.

Source files
------------

// File: rtl/bgr_palette_rom_pkg.sv
// Shared constants and ROM content definitions for the BGR palette display path.
// ROM images are defined procedurally per init-file name so every tool sees identical contents.
package bgr_palette_rom_pkg;

  localparam int FRAME_W   = 640;
  localparam int FRAME_H   = 480;
  localparam int SPR_W     = 28;
  localparam int SPR_H     = 28;
  localparam int PAL_DEPTH = 256;

  localparam int PIX_AW = 19;
  localparam int PAL_AW = 8;
  localparam int SPR_AW = 10;
  localparam int IDX_W  = 8;
  localparam int BGR_W  = 24;

  localparam logic [BGR_W-1:0] WALL_COLOR = 24'hFF5757;

  typedef enum logic [1:0] {
    ROM_NONE,
    ROM_PIX,
    ROM_PAL,
    ROM_SPR
  } rom_kind_e;

  function automatic rom_kind_e rom_kind(input string f);
    if (f == "bgr_pixel.mif") return ROM_PIX;
    if (f == "bgr_color.mif") return ROM_PAL;
    if (f == "blue_NE.mif")   return ROM_SPR;
    return ROM_NONE;
  endfunction

  // Word at an in-range address; the low address byte fully determines every image.
  function automatic logic [BGR_W-1:0] rom_word(input rom_kind_e k, input logic [7:0] a);
    case (k)
      ROM_PIX, ROM_SPR: return {16'h0000, a};
      ROM_PAL:          return {a, ~a, a};
      default:          return '0;
    endcase
  endfunction

endpackage

// File: rtl/bgr_palette_rom_rom_sync.sv
// Generic read-only memory with registered, enabled read and zero for out-of-range addresses.
// DUAL adds a second independent read port onto the same contents.
module rom_sync
  import bgr_palette_rom_pkg::*;
#(
  parameter int    DW        = 8,
  parameter int    AW        = 19,
  parameter int    DEPTH     = 307200,
  parameter string INIT_FILE = "",
  parameter bit    DUAL      = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_a_i,
  input  logic [AW-1:0] addr_a_i,
  output logic [DW-1:0] q_a_o,
  input  logic          en_b_i,
  input  logic [AW-1:0] addr_b_i,
  output logic [DW-1:0] q_b_o
);

  localparam rom_kind_e KIND = rom_kind(INIT_FILE);

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    if (32'(a) >= DEPTH) return '0;
    return DW'(rom_word(KIND, a[7:0]));
  endfunction

  logic [DW-1:0] q_a_q, q_a_d;

  assign q_a_d = en_a_i ? rd(addr_a_i) : q_a_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_a_q <= '0;
    else         q_a_q <= q_a_d;
  end

  assign q_a_o = q_a_q;

  if (DUAL) begin : g_port_b
    logic [DW-1:0] q_b_q, q_b_d;

    assign q_b_d = en_b_i ? rd(addr_b_i) : q_b_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) q_b_q <= '0;
      else         q_b_q <= q_b_d;
    end

    assign q_b_o = q_b_q;
  end else begin : g_no_port_b
    logic unused_b;
    assign unused_b = ^{en_b_i, addr_b_i};
    assign q_b_o    = '0;
  end

endmodule

// File: rtl/bgr_palette_rom.sv
// Frame pixel-index ROM (dual read) feeding a palette ROM, plus an independent sprite ROM.
// Pixel index to colour is a two-stage registered pipeline accepting one address per cycle.
module bgr_palette_rom
  import bgr_palette_rom_pkg::*;
#(
  parameter int    PIX_DEPTH = 307200,
  parameter string PIX_INIT  = "bgr_pixel.mif",
  parameter string PAL_INIT  = "bgr_color.mif",
  parameter int    SPR_DEPTH = 784,
  parameter string SPR_INIT  = "blue_NE.mif"
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic [PIX_AW-1:0] address_a,
  input  logic              rden_a,
  input  logic [PIX_AW-1:0] address_b,
  input  logic              rden_b,
  output logic [IDX_W-1:0]  q_a,
  output logic [IDX_W-1:0]  q_b,
  output logic [BGR_W-1:0]  bgr_data,
  input  logic [SPR_AW-1:0] spr_addr,
  output logic [IDX_W-1:0]  spr_q
);

  logic [BGR_W-1:0] unused_pal_b;
  logic [IDX_W-1:0] unused_spr_b;

  rom_sync #(
    .DW(IDX_W), .AW(PIX_AW), .DEPTH(PIX_DEPTH), .INIT_FILE(PIX_INIT), .DUAL(1'b1)
  ) u_pix (
    .clk_i(iVGA_CLK), .rst_ni(iRST_n),
    .en_a_i(rden_a), .addr_a_i(address_a), .q_a_o(q_a),
    .en_b_i(rden_b), .addr_b_i(address_b), .q_b_o(q_b)
  );

  // Palette reads every cycle from the held q_a, so colour tracks it even when port A is idle.
  rom_sync #(
    .DW(BGR_W), .AW(PAL_AW), .DEPTH(PAL_DEPTH), .INIT_FILE(PAL_INIT), .DUAL(1'b0)
  ) u_pal (
    .clk_i(iVGA_CLK), .rst_ni(iRST_n),
    .en_a_i(1'b1), .addr_a_i(q_a), .q_a_o(bgr_data),
    .en_b_i(1'b0), .addr_b_i('0), .q_b_o(unused_pal_b)
  );

  rom_sync #(
    .DW(IDX_W), .AW(SPR_AW), .DEPTH(SPR_DEPTH), .INIT_FILE(SPR_INIT), .DUAL(1'b0)
  ) u_spr (
    .clk_i(iVGA_CLK), .rst_ni(iRST_n),
    .en_a_i(1'b1), .addr_a_i(spr_addr), .q_a_o(spr_q),
    .en_b_i(1'b0), .addr_b_i('0), .q_b_o(unused_spr_b)
  );

endmodule

// File: tb/tb_bgr_palette_rom.sv
// Scoreboard bench: stimulus queues expected outputs per clock edge, a monitor checks them.
module tb_bgr_palette_rom;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [18:0] a_a   = '0;
  logic [18:0] a_b   = '0;
  logic        ra    = 1'b0;
  logic        rb    = 1'b0;
  logic [9:0]  sa    = '0;
  logic [7:0]  q_a, q_b, spr_q;
  logic [23:0] bgr_data;

  always #5 clk = ~clk;

  bgr_palette_rom dut (
    .iVGA_CLK(clk), .iRST_n(rst_n),
    .address_a(a_a), .rden_a(ra),
    .address_b(a_b), .rden_b(rb),
    .q_a(q_a), .q_b(q_b), .bgr_data(bgr_data),
    .spr_addr(sa), .spr_q(spr_q)
  );

  typedef struct {
    int          cyc;
    int          sel;
    logic [23:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  int   last_e = 0;
  logic [7:0] m_qa = '0, m_qb = '0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [7:0] pix(input logic [18:0] a);
    return (a < 19'd307200) ? a[7:0] : 8'h00;
  endfunction

  function automatic logic [23:0] pal(input logic [7:0] i);
    return {i, ~i, i};
  endfunction

  function automatic logic [7:0] sprm(input logic [9:0] s);
    return (s < 10'd784) ? s[7:0] : 8'h00;
  endfunction

  function automatic logic [23:0] act_of(input int sel);
    case (sel)
      0:       return {16'h0, q_a};
      1:       return {16'h0, q_b};
      2:       return bgr_data;
      default: return {16'h0, spr_q};
    endcase
  endfunction

  task automatic cmp(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %h want %h", name, edge_cnt, act, exp);
    end
  endtask

  task automatic expect_at(input int cyc, input int sel, input logic [23:0] v, input string n);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.exp = v; e.name = n;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t keep[$];
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].cyc == edge_cnt) cmp(sb[i].name, act_of(sb[i].sel), sb[i].exp);
      else if (sb[i].cyc < edge_cnt) begin
        checks++; errors++;
        $display("FAIL %s missed: due edge %0d now %0d", sb[i].name, sb[i].cyc, edge_cnt);
      end else keep.push_back(sb[i]);
    end
    sb = keep;
  end

  // Drive one cycle of inputs (caller is at a negedge) and queue the model's predictions.
  task automatic apply(input logic [18:0] a, input logic r_a, input logic [18:0] b,
                       input logic r_b, input logic [9:0] s);
    logic [7:0] old;
    a_a = a; ra = r_a; a_b = b; rb = r_b; sa = s;
    last_e = edge_cnt;
    old = m_qa;
    if (r_a) m_qa = pix(a);
    if (r_b) m_qb = pix(b);
    expect_at(last_e + 1, 0, {16'h0, m_qa}, "q_a");
    expect_at(last_e + 1, 1, {16'h0, m_qb}, "q_b");
    expect_at(last_e + 1, 3, {16'h0, sprm(s)}, "spr_q");
    expect_at(last_e + 1, 2, pal(old), "bgr_data");
    expect_at(last_e + 2, 2, pal(m_qa), "bgr_data_pipe");
  endtask

  task automatic step(input logic [18:0] a, input logic r_a, input logic [18:0] b,
                      input logic r_b, input logic [9:0] s);
    @(negedge clk);
    apply(a, r_a, b, r_b, s);
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, "_q_a"}, {16'h0, q_a}, 24'h0);
    cmp({tag, "_q_b"}, {16'h0, q_b}, 24'h0);
    cmp({tag, "_spr_q"}, {16'h0, spr_q}, 24'h0);
    cmp({tag, "_bgr"}, bgr_data, 24'h0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(negedge clk);
    check_zero("reset_held");
    rst_n = 1'b1;
    apply(19'd0, 1'b0, 19'd0, 1'b0, 10'd0);

    // Single read: index after one edge, colour after two.
    step(19'd5, 1'b1, 19'd0, 1'b0, 10'd0);
    expect_at(last_e + 1, 0, 24'h000005, "hand_q_a_5");
    expect_at(last_e + 2, 2, 24'h05FA05, "hand_bgr_5");
    step(19'd0, 1'b0, 19'd0, 1'b0, 10'd0);

    // Back-to-back stream, no bubbles.
    for (int i = 0; i < 10; i++) begin
      step(19'(i), 1'b1, 19'd0, 1'b0, 10'd0);
      expect_at(last_e + 1, 0, 24'(i), "hand_stream_q_a");
    end

    // Hold on disabled port A; palette keeps re-reading held index.
    step(19'd300, 1'b1, 19'd0, 1'b0, 10'd0);
    step(19'd7, 1'b0, 19'd0, 1'b0, 10'd0);
    expect_at(last_e + 1, 0, 24'h00002C, "hand_hold_q_a");
    expect_at(last_e + 1, 2, 24'h2CD32C, "hand_hold_bgr");
    step(19'd7, 1'b0, 19'd0, 1'b0, 10'd0);
    expect_at(last_e + 1, 0, 24'h00002C, "hand_hold_q_a2");
    expect_at(last_e + 1, 2, 24'h2CD32C, "hand_hold_bgr2");

    // Dual port, last valid address and out-of-range.
    step(19'd10, 1'b1, 19'd307199, 1'b1, 10'd0);
    expect_at(last_e + 1, 0, 24'h00000A, "hand_dual_q_a");
    expect_at(last_e + 1, 1, 24'h0000FF, "hand_last_q_b");
    step(19'd10, 1'b1, 19'd307200, 1'b1, 10'd0);
    expect_at(last_e + 1, 1, 24'h000000, "hand_oor_q_b");
    step(19'd42, 1'b1, 19'd42, 1'b1, 10'd0);
    expect_at(last_e + 1, 0, 24'h00002A, "hand_same_q_a");
    expect_at(last_e + 1, 1, 24'h00002A, "hand_same_q_b");
    step(19'd524287, 1'b1, 19'd9, 1'b0, 10'd0);
    expect_at(last_e + 1, 0, 24'h000000, "hand_max_q_a");
    expect_at(last_e + 1, 1, 24'h00002A, "hand_hold_q_b");

    // Sprite ROM edges.
    step(19'd0, 1'b0, 19'd0, 1'b0, 10'd783);
    expect_at(last_e + 1, 3, 24'h00000F, "hand_spr_783");
    step(19'd0, 1'b0, 19'd0, 1'b0, 10'd900);
    expect_at(last_e + 1, 3, 24'h000000, "hand_spr_900");
    step(19'd0, 1'b0, 19'd0, 1'b0, 10'd784);
    expect_at(last_e + 1, 3, 24'h000000, "hand_spr_784");
    step(19'd0, 1'b0, 19'd0, 1'b0, 10'd27);
    expect_at(last_e + 1, 3, 24'h00001B, "hand_spr_27");

    // Reset mid-stream discards in-flight reads.
    step(19'd100, 1'b1, 19'd200, 1'b1, 10'd50);
    step(19'd101, 1'b1, 19'd201, 1'b1, 10'd51);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    sb = {};
    m_qa = '0;
    m_qb = '0;
    @(negedge clk);
    check_zero("midreset_held");
    rst_n = 1'b1;
    apply(19'd3, 1'b1, 19'd0, 1'b0, 10'd0);
    expect_at(last_e + 1, 0, 24'h000003, "hand_rel_q_a");
    expect_at(last_e + 2, 2, 24'h03FC03, "hand_rel_bgr");
    step(19'd4, 1'b1, 19'd0, 1'b0, 10'd0);

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      checks++;
      errors += sb.size();
      $display("FAIL drain: %0d expectations still pending, want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
